// File: rtl/hiscore_upload.sv
// hiscore_upload
//   Streams the game's high-score NVRAM back to the HPS during an upload
//   session. Each HPS read strobe becomes one NVRAM read; the returned byte
//   is presented on ioctl_din. While a session is open the game CPU is held
//   off NVRAM so the image cannot change under the transfer.
//
// Ports
//   clk_sys       sole clock, rising edge
//   Reset_I       asynchronous active-low reset
//   ioctl_upload  HPS upload session active (level)
//   ioctl_rd      one-cycle read strobe from HPS
//   ioctl_addr    byte address, sampled with ioctl_rd
//   ioctl_din     byte returned to HPS, held until the next read completes
//   ram_addr      NVRAM read address
//   ram_rd        one-cycle NVRAM read enable
//   ram_q         NVRAM data, valid RAM_LAT cycles after ram_rd
//   cpu_hold      freezes game CPU NVRAM writes (high outside IDLE)
//   busy          high while a fetch is in flight
//   done          one-cycle pulse when a session ends
//
// Optional feature
//   HISCORE_CHECKSUM_EN: a read of address 2^ADDR_W returns the two's
//   complement of the running byte sum of the session, so the image plus
//   this trailer sums to zero mod 256. Undefined: that address reads 8'hFF
//   like any other out-of-range address and no sum logic exists.

module hiscore_upload #(
    parameter int ADDR_W  = 8,
    parameter int RAM_LAT = 1
) (
    input  logic              clk_sys,
    input  logic              Reset_I,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_q,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READY = 2'd1;
    localparam logic [1:0] S_FETCH = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    localparam logic [24:0] DEPTH = 25'd1 << ADDR_W;

    logic [1:0]        state_q, state_d;
    logic              upload_q, upload_d;
    logic [7:0]        din_q, din_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_rd_q, ram_rd_d;
    logic              done_q, done_d;
    logic              pend_v_q, pend_v_d;
    logic [24:0]       pend_addr_q, pend_addr_d;
    logic              cur_inr_q, cur_inr_d;
    logic [1:0]        cnt_q, cnt_d;
`ifdef HISCORE_CHECKSUM_EN
    logic              cur_csum_q, cur_csum_d;
    logic [7:0]        sum_q, sum_d;
`endif

    logic              issue;
    logic [24:0]       issue_addr;

    always_comb begin
        state_d     = state_q;
        upload_d    = ioctl_upload;
        din_d       = din_q;
        ram_addr_d  = ram_addr_q;
        ram_rd_d    = 1'b0;
        done_d      = 1'b0;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        cur_inr_d   = cur_inr_q;
        cnt_d       = cnt_q;
        issue       = 1'b0;
        issue_addr  = ioctl_addr;
`ifdef HISCORE_CHECKSUM_EN
        cur_csum_d  = cur_csum_q;
        sum_d       = sum_q;
`endif

        case (state_q)
            S_IDLE: begin
                // Reads while idle are ignored; only a fresh session opens us.
                if (ioctl_upload && !upload_q) begin
                    state_d = S_READY;
`ifdef HISCORE_CHECKSUM_EN
                    sum_d   = 8'd0;
`endif
                end
            end
            S_READY: begin
                // A parked request goes first; a strobe arriving in the same
                // cycle takes its place in the slot rather than being lost.
                if (pend_v_q) begin
                    issue      = 1'b1;
                    issue_addr = pend_addr_q;
                    pend_v_d   = ioctl_rd;
                    if (ioctl_rd) begin
                        pend_addr_d = ioctl_addr;
                    end
                end else if (ioctl_rd) begin
                    issue      = 1'b1;
                    issue_addr = ioctl_addr;
                end
            end
            S_FETCH: begin
                state_d = S_WAIT;
                cnt_d   = 2'(RAM_LAT - 1);
                if (ioctl_rd && !pend_v_q) begin
                    pend_v_d    = 1'b1;
                    pend_addr_d = ioctl_addr;
                end
            end
            default: begin // S_WAIT
                if (ioctl_rd && !pend_v_q) begin
                    pend_v_d    = 1'b1;
                    pend_addr_d = ioctl_addr;
                end
                if (cnt_q == 2'd0) begin
                    state_d = S_READY;
                    if (cur_inr_q) begin
                        din_d = ram_q;
`ifdef HISCORE_CHECKSUM_EN
                        sum_d = sum_q + ram_q;
                    end else if (cur_csum_q) begin
                        din_d = 8'd0 - sum_q;
`endif
                    end else begin
                        din_d = 8'hFF;
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
        endcase

        // Out-of-range fetches still walk FETCH/WAIT so every read answers
        // with the same latency; they just never touch the NVRAM.
        if (issue) begin
            state_d   = S_FETCH;
            cur_inr_d = (issue_addr < DEPTH);
`ifdef HISCORE_CHECKSUM_EN
            cur_csum_d = (issue_addr == DEPTH);
`endif
            if (issue_addr < DEPTH) begin
                ram_rd_d   = 1'b1;
                ram_addr_d = issue_addr[ADDR_W-1:0];
            end
        end

        // Session closed by the HPS: abandon any fetch in progress without
        // disturbing the last byte handed out.
        if (state_q != S_IDLE && !ioctl_upload) begin
            state_d  = S_IDLE;
            pend_v_d = 1'b0;
            ram_rd_d = 1'b0;
            din_d    = din_q;
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge Reset_I) begin
        if (!Reset_I) begin
            state_q     <= S_IDLE;
            upload_q    <= 1'b0;
            din_q       <= 8'h00;
            ram_addr_q  <= '0;
            ram_rd_q    <= 1'b0;
            done_q      <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
            cur_inr_q   <= 1'b0;
            cnt_q       <= 2'd0;
`ifdef HISCORE_CHECKSUM_EN
            cur_csum_q  <= 1'b0;
            sum_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            upload_q    <= upload_d;
            din_q       <= din_d;
            ram_addr_q  <= ram_addr_d;
            ram_rd_q    <= ram_rd_d;
            done_q      <= done_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            cur_inr_q   <= cur_inr_d;
            cnt_q       <= cnt_d;
`ifdef HISCORE_CHECKSUM_EN
            cur_csum_q  <= cur_csum_d;
            sum_q       <= sum_d;
`endif
        end
    end

    assign ioctl_din = din_q;
    assign ram_addr  = ram_addr_q;
    assign ram_rd    = ram_rd_q;
    assign done      = done_q;
    assign cpu_hold  = (state_q != S_IDLE);
    assign busy      = (state_q == S_FETCH) || (state_q == S_WAIT);

endmodule

// File: tb/tb_hiscore_upload.sv
// Testbench for hiscore_upload: directed scenarios plus a randomized stream
// checked against a request-timeline model of the upload engine.

module tb_hiscore_upload;

    localparam int ADDR_W  = 8;
    localparam int RAM_LAT = 1;

    logic              clk_sys = 1'b0;
    logic              Reset_I;
    logic              ioctl_upload;
    logic              ioctl_rd;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_din;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd;
    logic [7:0]        ram_q;
    logic              cpu_hold;
    logic              busy;
    logic              done;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] mem [0:255];
    logic [7:0] q_pipe [RAM_LAT];

    always #5 clk_sys = ~clk_sys;

    hiscore_upload #(.ADDR_W(ADDR_W), .RAM_LAT(RAM_LAT)) dut (
        .clk_sys     (clk_sys),
        .Reset_I     (Reset_I),
        .ioctl_upload(ioctl_upload),
        .ioctl_rd    (ioctl_rd),
        .ioctl_addr  (ioctl_addr),
        .ioctl_din   (ioctl_din),
        .ram_addr    (ram_addr),
        .ram_rd      (ram_rd),
        .ram_q       (ram_q),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .done        (done)
    );

    // NVRAM: data only appears for a real read; otherwise a poison byte.
    always @(posedge clk_sys) begin
        q_pipe[0] <= ram_rd ? mem[ram_addr] : 8'h5A;
        for (int i = 1; i < RAM_LAT; i++) q_pipe[i] <= q_pipe[i-1];
    end
    assign ram_q = q_pipe[RAM_LAT-1];

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start_session;
        ioctl_upload = 1'b1;
        tick();
    endtask

    task automatic end_session;
        ioctl_upload = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset;
        Reset_I = 1'b0; ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_addr = '0;
        repeat (3) tick();
        n_cmp++;
        if ({ioctl_din, ram_addr, ram_rd, cpu_hold, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got din=%h addr=%h rd=%b hold=%b busy=%b done=%b required all zero",
                     ioctl_din, ram_addr, ram_rd, cpu_hold, busy, done);
        end
        Reset_I = 1'b1;
        tick();
    endtask

    task automatic test_idle_ignore;
        ioctl_rd = 1'b1; ioctl_addr = 25'd3;
        tick();
        ioctl_rd = 1'b0;
        n_cmp++;
        if ({ram_rd, busy, cpu_hold} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_ignore_ctrl: got rd/busy/hold=%b%b%b required 000", ram_rd, busy, cpu_hold);
        end
        tick(); tick();
        n_cmp++;
        if (ioctl_din !== 8'h00) begin
            n_fail++;
            $display("FAIL idle_ignore_din: got %h required 00", ioctl_din);
        end
    endtask

    task automatic test_single;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        start_session();
        n_cmp++;
        if (cpu_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL single_hold: got %b required 1", cpu_hold);
        end
        ioctl_rd = 1'b1; ioctl_addr = 25'h05;
        tick();                                   // T+1
        ioctl_rd = 1'b0;
        n_cmp++;
        if ({ram_rd, ram_addr, busy} !== {1'b1, 8'h05, 1'b1}) begin
            n_fail++;
            $display("FAIL single_t1: got rd=%b addr=%h busy=%b required rd=1 addr=05 busy=1", ram_rd, ram_addr, busy);
        end
        tick();                                   // T+2
        n_cmp++;
        if ({ram_rd, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL single_t2: got rd=%b busy=%b required rd=0 busy=1", ram_rd, busy);
        end
        tick();                                   // T+3
        n_cmp++;
        if ({ioctl_din, busy} !== {8'h05, 1'b0}) begin
            n_fail++;
            $display("FAIL single_t3: got din=%h busy=%b required din=05 busy=0", ioctl_din, busy);
        end
    endtask

    task automatic test_pending;
        ioctl_rd = 1'b1; ioctl_addr = 25'h10;
        tick();                                   // T+1
        ioctl_rd = 1'b0;
        n_cmp++;
        if ({ram_rd, ram_addr} !== {1'b1, 8'h10}) begin
            n_fail++;
            $display("FAIL pend_first_rd: got rd=%b addr=%h required rd=1 addr=10", ram_rd, ram_addr);
        end
        tick();                                   // T+2
        ioctl_rd = 1'b1; ioctl_addr = 25'h11;
        tick();                                   // T+3
        ioctl_rd = 1'b0;
        n_cmp++;
        if (ioctl_din !== 8'h10) begin
            n_fail++;
            $display("FAIL pend_first_din: got %h required 10", ioctl_din);
        end
        tick();                                   // T+4
        n_cmp++;
        if ({ram_rd, ram_addr} !== {1'b1, 8'h11}) begin
            n_fail++;
            $display("FAIL pend_second_rd: got rd=%b addr=%h required rd=1 addr=11", ram_rd, ram_addr);
        end
        tick(); tick();                           // T+6
        n_cmp++;
        if ({ioctl_din, busy} !== {8'h11, 1'b0}) begin
            n_fail++;
            $display("FAIL pend_second_din: got din=%h busy=%b required din=11 busy=0", ioctl_din, busy);
        end
    endtask

    task automatic test_drop;
        int rd_cnt;
        logic [7:0] last_a;
        rd_cnt = 0; last_a = 8'h00;
        ioctl_rd = 1'b1; ioctl_addr = 25'h20;
        tick();
        ioctl_addr = 25'h21;                      // captured into the slot
        tick();
        ioctl_addr = 25'h22;                      // slot full: dropped
        tick();
        ioctl_rd = 1'b0;
        n_cmp++;
        if (ioctl_din !== 8'h20) begin
            n_fail++;
            $display("FAIL drop_first_din: got %h required 20", ioctl_din);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ram_rd) begin rd_cnt++; last_a = ram_addr; end
        end
        n_cmp++;
        if ({rd_cnt[3:0], last_a, ioctl_din} !== {4'd1, 8'h21, 8'h21}) begin
            n_fail++;
            $display("FAIL drop_result: got reads=%0d addr=%h din=%h required reads=1 addr=21 din=21",
                     rd_cnt, last_a, ioctl_din);
        end
    endtask

    task automatic test_oor;
        ioctl_rd = 1'b1; ioctl_addr = 25'h1000;
        tick();
        ioctl_rd = 1'b0;
        n_cmp++;
        if ({ram_rd, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL oor_t1: got rd=%b busy=%b required rd=0 busy=1", ram_rd, busy);
        end
        tick(); tick();
        n_cmp++;
        if (ioctl_din !== 8'hFF) begin
            n_fail++;
            $display("FAIL oor_din: got %h required ff", ioctl_din);
        end
    endtask

    task automatic read_all(input logic [7:0] exp_trailer, input string tag);
        start_session();
        for (int a = 0; a <= 256; a++) begin
            ioctl_rd = 1'b1; ioctl_addr = 25'(a);
            tick();
            ioctl_rd = 1'b0;
            tick(); tick();
            if (a == 100) begin
                n_cmp++;
                if (ioctl_din !== mem[100]) begin
                    n_fail++;
                    $display("FAIL %s_byte100: got %h required %h", tag, ioctl_din, mem[100]);
                end
            end
        end
        n_cmp++;
        if (ioctl_din !== exp_trailer) begin
            n_fail++;
            $display("FAIL %s_trailer: got %h required %h", tag, ioctl_din, exp_trailer);
        end
    endtask

    task automatic test_checksum;
        end_session();
        for (int i = 0; i < 256; i++) mem[i] = 8'h01;
`ifdef HISCORE_CHECKSUM_EN
        read_all(8'h00, "csum_ones");
`else
        read_all(8'hFF, "csum_ones");
`endif
        end_session();
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
`ifdef HISCORE_CHECKSUM_EN
        read_all(8'h80, "csum_ramp");
`else
        read_all(8'hFF, "csum_ramp");
`endif
    endtask

    task automatic test_abort;
        logic [7:0] held;
        int done_cnt;
        held = ioctl_din;
        done_cnt = 0;
        ioctl_rd = 1'b1; ioctl_addr = 25'h33;
        tick();                                   // T+1 FETCH
        ioctl_rd = 1'b0;
        tick();                                   // T+2 WAIT
        ioctl_upload = 1'b0;
        tick();                                   // T+3
        n_cmp++;
        if ({cpu_hold, done, ioctl_din} !== {1'b0, 1'b1, held}) begin
            n_fail++;
            $display("FAIL abort_t3: got hold=%b done=%b din=%h required hold=0 done=1 din=%h",
                     cpu_hold, done, ioctl_din, held);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done) done_cnt++;
        end
        n_cmp++;
        if ({done_cnt[3:0], ioctl_din, busy} !== {4'd0, held, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_after: got extra_done=%0d din=%h busy=%b required 0 %h 0", done_cnt, ioctl_din, busy, held);
        end
        // Reset asserted in the middle of a fetch takes effect at once.
        start_session();
        ioctl_rd = 1'b1; ioctl_addr = 25'h44;
        tick();
        ioctl_rd = 1'b0;
        Reset_I = 1'b0;
        #1;
        n_cmp++;
        if ({ioctl_din, ram_addr, ram_rd, cpu_hold, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_midfetch: got din=%h addr=%h rd=%b hold=%b busy=%b done=%b required all zero",
                     ioctl_din, ram_addr, ram_rd, cpu_hold, busy, done);
        end
        tick(); tick();
        n_cmp++;
        if ({ioctl_din, ram_addr, ram_rd, cpu_hold, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_held: got din=%h addr=%h rd=%b hold=%b busy=%b done=%b required all zero",
                     ioctl_din, ram_addr, ram_rd, cpu_hold, busy, done);
        end
        ioctl_upload = 1'b0;
        Reset_I = 1'b1;
        tick();
    endtask

    // Timeline model: a request served at cycle s shows ram_rd at s+1, busy
    // over s+1..s+1+L, its byte at s+2+L, and the engine is free from s+2+L.
    bit         exp_rd    [int];
    logic [7:0] exp_rda   [int];
    bit         exp_busy  [int];
    logic [7:0] exp_din   [int];
    int         free_at;
    logic [7:0] sum_m;

    task automatic serve(input int s, input logic [24:0] a);
        logic [7:0] v;
        if (a < 25'd256) begin
            exp_rd[s+1]  = 1'b1;
            exp_rda[s+1] = a[7:0];
            v = mem[a[7:0]];
            sum_m = sum_m + v;
`ifdef HISCORE_CHECKSUM_EN
        end else if (a == 25'd256) begin
            v = 8'd0 - sum_m;
`endif
        end else begin
            v = 8'hFF;
        end
        for (int k = 1; k <= 1 + RAM_LAT; k++) exp_busy[s+k] = 1'b1;
        exp_din[s+2+RAM_LAT] = v;
        free_at = s + 2 + RAM_LAT;
    endtask

    task automatic test_random;
        int N;
        bit pend_v, din_known, rd;
        logic [24:0] pend_a, a;
        logic [7:0] din_exp;
        int r;
        N = 500;
        pend_v = 0; pend_a = '0; din_known = 0; din_exp = 8'h00;
        free_at = 0; sum_m = 8'd0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        start_session();
        for (int c = 0; c < N; c++) begin
            if (exp_din.exists(c)) begin din_known = 1; din_exp = exp_din[c]; end
            n_cmp++;
            if (ram_rd !== exp_rd.exists(c) || (exp_rd.exists(c) && ram_addr !== exp_rda[c])) begin
                n_fail++;
                $display("FAIL rand_ramrd c=%0d: got rd=%b addr=%h required rd=%b addr=%h",
                         c, ram_rd, ram_addr, exp_rd.exists(c), exp_rd.exists(c) ? exp_rda[c] : ram_addr);
            end
            n_cmp++;
            if ({busy, cpu_hold} !== {exp_busy.exists(c), 1'b1}) begin
                n_fail++;
                $display("FAIL rand_busy c=%0d: got busy=%b hold=%b required busy=%b hold=1",
                         c, busy, cpu_hold, exp_busy.exists(c));
            end
            if (din_known) begin
                n_cmp++;
                if (ioctl_din !== din_exp) begin
                    n_fail++;
                    $display("FAIL rand_din c=%0d: got %h required %h", c, ioctl_din, din_exp);
                end
            end
            rd = ($urandom_range(0, 2) == 0) && (c < N - 12);
            r  = $urandom_range(0, 9);
            if (r < 7)       a = 25'($urandom_range(0, 255));
            else if (r == 7) a = 25'd256;
            else if (r == 8) a = 25'($urandom_range(257, 32'h1FF_FFFF));
            else             a = 25'h1000;
            if (c == free_at && pend_v) begin
                serve(c, pend_a);
                pend_v = rd;
                if (rd) pend_a = a;
            end else if (rd) begin
                if (c >= free_at) serve(c, a);
                else if (!pend_v) begin pend_v = 1; pend_a = a; end
            end
            ioctl_rd = rd; ioctl_addr = a;
            tick();
        end
        ioctl_rd = 1'b0;
        end_session();
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_single();
        test_pending();
        test_drop();
        test_oor();
        test_checksum();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hiscore_upload.md
HISCORE_UPLOAD -- requirements
Module: hiscore_upload

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: NVRAM depth is 2^ADDR_W bytes.
REQ-002 SHALL have parameter RAM_LAT, default 1, legal 1..3: NVRAM read latency in clk_sys cycles.
REQ-003 SHALL have port clk_sys, input, 1: sole clock, all logic rising-edge.
REQ-004 SHALL have port Reset_I, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port ioctl_upload, input, 1: HPS upload session active.
REQ-006 SHALL have port ioctl_rd, input, 1: one-cycle read strobe from HPS.
REQ-007 SHALL have port ioctl_addr, input, 25: byte address, sampled on ioctl_rd.
REQ-008 SHALL have port ioctl_din, output, 8: byte returned to HPS.
REQ-009 SHALL have port ram_addr, output, ADDR_W: NVRAM read address.
REQ-010 SHALL have port ram_rd, output, 1: one-cycle NVRAM read enable.
REQ-011 SHALL have port ram_q, input, 8: NVRAM read data, valid RAM_LAT cycles after ram_rd.
REQ-012 SHALL have port cpu_hold, output, 1: freezes game CPU NVRAM writes.
REQ-013 SHALL have port busy, output, 1: high while a fetch is in flight.
REQ-014 SHALL have port done, output, 1: one-cycle pulse when a session ends.

Function
REQ-015 SHALL implement states IDLE, READY, FETCH, WAIT.
- IDLE -> READY on ioctl_upload rising edge.
- READY -> FETCH on ioctl_rd.
- FETCH -> WAIT after one cycle.
- WAIT -> READY after RAM_LAT cycles.
REQ-016 SHALL assert cpu_hold in every state except IDLE.
REQ-017 SHALL, for ioctl_rd at cycle T with ioctl_addr < 2^ADDR_W, drive ram_rd=1 and ram_addr=ioctl_addr[ADDR_W-1:0] at T+1.
REQ-018 SHALL update ioctl_din with ram_q at T+2+RAM_LAT (T+3 at default) and hold it until the next update.
REQ-019 SHALL, for ioctl_addr >= 2^ADDR_W, issue no ram_rd and return 8'hFF with the same latency, except as REQ-027 states.
REQ-020 SHALL hold busy high from T+1 through T+1+RAM_LAT inclusive.
REQ-021 SHALL capture an ioctl_rd that arrives during FETCH or WAIT into a one-deep pending slot, holding its address, and service it directly after returning to READY.
REQ-022 SHALL drop any further ioctl_rd while the pending slot is full; the last serviced ioctl_din is unchanged by the dropped request.
REQ-023 SHALL keep a running byte sum, modulo 256, that clears on ioctl_upload rise and adds every in-range ram_q returned.
REQ-024 SHALL, on ioctl_upload fall in any non-IDLE state, abort any fetch, clear the pending slot, go to IDLE, deassert cpu_hold the next cycle, and pulse done for exactly one cycle.
REQ-025 SHALL ignore ioctl_rd in IDLE, producing no ram_rd and no ioctl_din change.

Reset
REQ-026 SHALL, while Reset_I=0 and immediately on its assertion even mid-fetch, force: state IDLE, ioctl_din=8'h00, ram_addr=0, ram_rd=0, cpu_hold=0, busy=0, done=0, pending slot empty, byte sum=0.

Configuration
REQ-027 SHALL use macro HISCORE_CHECKSUM_EN: when defined, a read of ioctl_addr == 2^ADDR_W returns the two's complement of the byte sum, so all bytes plus the trailer sum to 0 mod 256; when undefined, that address returns 8'hFF per REQ-019 and no sum logic is synthesized.

Verification
REQ-028 SHALL test: RAM preloaded with 0x00..0xFF, upload rises, rd at addr 0x05 at cycle T -> ram_rd at T+1, ioctl_din=0x05 at T+3, busy high at T+1..T+2.
REQ-029 SHALL test: rd at 0x10 then rd at 0x11 two cycles later -> second request served from the pending slot, ioctl_din=0x10 then 0x11, no ram_rd lost.
REQ-030 SHALL test: rd at addr 0x1000 -> no ram_rd, ioctl_din=0xFF.
REQ-031 SHALL test: with HISCORE_CHECKSUM_EN, RAM all 0x01 and addresses 0..255 read in order, then address 256 read -> ioctl_din=0x00; with bytes 0x00..0xFF -> 0x80.
REQ-032 SHALL test: upload falls during WAIT -> done pulses once, cpu_hold low next cycle, ioctl_din unchanged; and Reset_I low mid-fetch -> all outputs at reset values.
